// File: rtl/fixed3_scale_seq_pkg.sv
// Shared Fixed3 math types: W-bit signed fixed point with F fractional bits,
// saturation limits, FSM state encoding and real-valued constructors for benches.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 32
`endif
`ifndef FIXED_FRAC_WIDTH
`define FIXED_FRAC_WIDTH 16
`endif

package fixed3_scale_seq_pkg;

    localparam int W = `FIXED_WIDTH;
    localparam int F = `FIXED_FRAC_WIDTH;

    typedef struct packed {
        logic signed [W-1:0] Value;
    } Fixed;

    typedef struct packed {
        Fixed [2:0] Dim;
    } Fixed3;

    localparam logic signed [W-1:0] FIXED_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] FIXED_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    // Round-to-nearest conversion from a real literal; only used by benches.
    function automatic Fixed _Fixed(input real x);
        real scaled;
        scaled = x * (2.0 ** F);
        scaled = (scaled >= 0.0) ? scaled + 0.5 : scaled - 0.5;
        _Fixed.Value = W'($rtoi(scaled));
    endfunction

    function automatic Fixed3 _Fixed3(input real x, input real y, input real z);
        _Fixed3.Dim[0] = _Fixed(x);
        _Fixed3.Dim[1] = _Fixed(y);
        _Fixed3.Dim[2] = _Fixed(z);
    endfunction

endpackage

// File: rtl/fixed3_scale_seq_if.sv
// Strobe/valid request bus of the Fixed3 scaler: the master issues v and s,
// the slave returns the scaled vector with valid/busy status.
interface fixed3_scale_seq_if;
    import fixed3_scale_seq_pkg::*;

    logic  strobe;
    Fixed3 v;
    Fixed  s;
    Fixed3 ov;
    logic  valid;
    logic  busy;

    modport master (output strobe, v, s, input ov, valid, busy);
    modport slave  (input strobe, v, s, output ov, valid, busy);
endinterface

// File: rtl/fixed_mul_sat.sv
// Combinational W x W signed fixed-point multiply with round-half-up and
// saturation to the Fixed range; intended to land in DSP slices.
module fixed_mul_sat
    import fixed3_scale_seq_pkg::*;
(
    input  Fixed a,
    input  Fixed b,
    output Fixed o
);

    localparam logic [2*W-1:0] ROUND_BIAS = (2*W)'(1) << (F - 1);

    logic        [2*W-1:0] prod;
    logic        [2*W-1:0] rounded;
    logic signed [2*W-1:0] shifted;

    // Sign-extended operands make the low 2W bits of the product exact,
    // so an unsigned multiply is sufficient.
    always_comb begin
        prod    = {{W{a.Value[W-1]}}, a.Value} * {{W{b.Value[W-1]}}, b.Value};
        rounded = prod + ROUND_BIAS;
        shifted = $signed(rounded) >>> F;
        o       = '0;
        if (shifted[2*W-1:W-1] == {(W+1){shifted[2*W-1]}}) begin
            o.Value = shifted[W-1:0];
        end else begin
            o.Value = shifted[2*W-1] ? FIXED_MIN : FIXED_MAX;
        end
    end

endmodule

// File: rtl/fixed3_scale_seq.sv
// Iterative Fixed3 scaler: ov = s * v, one component per cycle through a
// single shared saturating multiplier, with strobe/valid/busy handshake.
module fixed3_scale_seq
    import fixed3_scale_seq_pkg::*;
(
    input logic               clk,
    input logic               reset,
    fixed3_scale_seq_if.slave bus
);

    state_t     state;
    logic [1:0] k;
    Fixed3      v_reg;
    Fixed       s_reg;
    Fixed       operand;
    Fixed       product;

    always_comb begin
        case (k)
            2'd0:    operand = v_reg.Dim[0];
            2'd1:    operand = v_reg.Dim[1];
            default: operand = v_reg.Dim[2];
        endcase
    end

    fixed_mul_sat u_mul (
        .a(s_reg),
        .b(operand),
        .o(product)
    );

    // On the finishing edge (k==2) a new strobe is taken directly, which is
    // what sustains one vector every three cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= 2'd0;
            v_reg     <= '0;
            s_reg     <= '0;
            bus.ov    <= '0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.strobe) begin
                        v_reg    <= bus.v;
                        s_reg    <= bus.s;
                        k        <= 2'd0;
                        state    <= MUL;
                        bus.busy <= 1'b1;
                    end
                end
                MUL: begin
                    case (k)
                        2'd0:    bus.ov.Dim[0] <= product;
                        2'd1:    bus.ov.Dim[1] <= product;
                        default: bus.ov.Dim[2] <= product;
                    endcase
                    if (k == 2'd2) begin
                        bus.valid <= 1'b1;
                        if (bus.strobe) begin
                            v_reg <= bus.v;
                            s_reg <= bus.s;
                            k     <= 2'd0;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        k <= k + 2'd1;
                    end
                end
            endcase
        end
    end

endmodule
